// File: rtl/serial_arb_pkg.sv
// Shared types and constants for the serial port arbiter.
// The optional lock feature is enabled with the SERIAL_ARB_LOCK_EN macro.
package serial_arb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Operation encoding on op_0 / op_1
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Requester indices
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

endpackage

// File: rtl/serial_port_arbiter_rr_pick.sv
// Combinational two-way round-robin picker.
// On a tie the requester that was not served last wins.
module serial_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant from the request vector and last-served index
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_port_arbiter.sv
// Two-requester arbiter for the UART TX/RX FIFO ports.
// Handshake: a requester raises req (with op/wdata stable) and holds it
// until the one-cycle ack pulse; it lowers req on the edge that ends ack.
// Each transaction issues at most one FIFO strobe (tx_write or rx_read).
// Optional feature macro: SERIAL_ARB_LOCK_EN adds lock_0 / lock_1, which let
// the current grantee keep the port across consecutive transactions.
module serial_port_arbiter
  import serial_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       op_0,
  input  logic       op_1,
  input  logic [7:0] wdata_0,
  input  logic [7:0] wdata_1,
`ifdef SERIAL_ARB_LOCK_EN
  input  logic       lock_0,
  input  logic       lock_1,
`endif
  output logic       ack_0,
  output logic       ack_1,
  output logic [7:0] rdata_0,
  output logic [7:0] rdata_1,
  output logic [1:0] grant,
  input  logic       tx_full,
  output logic       tx_write,
  output logic [7:0] tx_data,
  input  logic       rx_empty,
  output logic       rx_read,
  input  logic [7:0] rx_data,
  output logic [1:0] fsm_state
);

  // Last WAIT count value before moving to ACK
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] pick;
  logic       last_q, last_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       locked_q, locked_d;
  logic       tx_strobe, rx_strobe, ack_fire;

  logic       own;
  logic       own_req;
  logic       own_op;
  logic       own_lock;
  logic [7:0] own_wdata;
  logic       ack_busy;

  // Grantee view of the requester inputs
  assign own       = grant_q[1];
  assign own_req   = own ? req_1 : req_0;
  assign own_op    = own ? op_1 : op_0;
  assign own_wdata = own ? wdata_1 : wdata_0;
`ifdef SERIAL_ARB_LOCK_EN
  assign own_lock  = own ? lock_1 : lock_0;
`else
  assign own_lock  = 1'b0;
`endif

  // The requester still sees ack high for one cycle after ACK; its req
  // drops only at the end of that cycle, so IDLE must not sample it yet.
  assign ack_busy  = ack_0 | ack_1;

  serial_rr_pick u_pick (
    .req   ({req_1, req_0}),
    .last  (last_q),
    .grant (pick)
  );

  // State and bookkeeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      cnt_q    <= 2'd0;
      rd_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      locked_q <= locked_d;
    end
  end

  // Next-state and strobe decisions
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    locked_d  = locked_q;
    tx_strobe = 1'b0;
    rx_strobe = 1'b0;
    ack_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ack_busy) begin
          if (locked_q) begin
            // Locked owner keeps the port; the other requester waits
            if (own_req) state_d = ST_ISSUE;
          end else if (pick != 2'b00) begin
            grant_d = pick;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        rd_d = (own_op == OP_READ);
        if (own_op == OP_WRITE) begin
          if (!tx_full) begin
            tx_strobe = 1'b1;
            state_d   = ST_ACK;
          end
        end else if (!rx_empty) begin
          rx_strobe = 1'b1;
          cnt_d     = 2'd0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) state_d = ST_ACK;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      ST_ACK: begin
        ack_fire = 1'b1;
        state_d  = ST_IDLE;
        if (own_lock) begin
          locked_d = 1'b1;
        end else begin
          locked_d = 1'b0;
          grant_d  = 2'b00;
          last_d   = own;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: strobes, data, ack and captured read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_write <= 1'b0;
      tx_data  <= 8'h00;
      rx_read  <= 1'b0;
      ack_0    <= 1'b0;
      ack_1    <= 1'b0;
      rdata_0  <= 8'h00;
      rdata_1  <= 8'h00;
    end else begin
      tx_write <= tx_strobe;
      rx_read  <= rx_strobe;
      ack_0    <= ack_fire & ~own;
      ack_1    <= ack_fire & own;
      if (tx_strobe) tx_data <= own_wdata;
      if (ack_fire && rd_q) begin
        if (own) rdata_1 <= rx_data;
        else     rdata_0 <= rx_data;
      end
    end
  end

  assign grant     = grant_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_serial_port_arbiter.sv
// Directed bench for serial_port_arbiter with scoreboards for TX bytes,
// grants and acks. Two instances: RD_LAT=1 (main) and RD_LAT=2 (latency).
// The lock scenario runs only when SERIAL_ARB_LOCK_EN is defined.
module tb_serial_port_arbiter;
  import serial_arb_pkg::*;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Main instance signals
  logic       req_0 = 1'b0, req_1 = 1'b0, op_0 = 1'b0, op_1 = 1'b0;
  logic [7:0] wdata_0 = 8'h00, wdata_1 = 8'h00;
  logic       tx_full = 1'b0, rx_empty = 1'b0;
  logic [7:0] rx_data = 8'hEE;
`ifdef SERIAL_ARB_LOCK_EN
  logic       lock_0 = 1'b0, lock_1 = 1'b0;
`endif
  logic       ack_0, ack_1, tx_write, rx_read;
  logic [7:0] rdata_0, rdata_1, tx_data;
  logic [1:0] grant, fsm_state;

  // Second instance (RD_LAT=2) signals
  logic       b_req_1 = 1'b0;
  logic       zero1 = 1'b0;
  logic [7:0] zero8 = 8'h00;
  logic [7:0] b_rx_data = 8'hEE;
  logic       b_ack_0, b_ack_1, b_tx_write, b_rx_read;
  logic [7:0] b_rdata_0, b_rdata_1, b_tx_data;
  logic [1:0] b_grant, b_fsm_state;

  serial_port_arbiter #(.RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
`ifdef SERIAL_ARB_LOCK_EN
    .lock_0(lock_0), .lock_1(lock_1),
`endif
    .ack_0(ack_0), .ack_1(ack_1), .rdata_0(rdata_0), .rdata_1(rdata_1),
    .grant(grant), .tx_full(tx_full), .tx_write(tx_write), .tx_data(tx_data),
    .rx_empty(rx_empty), .rx_read(rx_read), .rx_data(rx_data),
    .fsm_state(fsm_state)
  );

  serial_port_arbiter #(.RD_LAT(2)) dut_lat2 (
    .clock(clock), .reset(reset),
    .req_0(zero1), .req_1(b_req_1), .op_0(zero1), .op_1(zero1),
    .wdata_0(zero8), .wdata_1(zero8),
`ifdef SERIAL_ARB_LOCK_EN
    .lock_0(zero1), .lock_1(zero1),
`endif
    .ack_0(b_ack_0), .ack_1(b_ack_1), .rdata_0(b_rdata_0), .rdata_1(b_rdata_1),
    .grant(b_grant), .tx_full(zero1), .tx_write(b_tx_write), .tx_data(b_tx_data),
    .rx_empty(zero1), .rx_read(b_rx_read), .rx_data(b_rx_data),
    .fsm_state(b_fsm_state)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx_q[$];
  logic [1:0] exp_grant_q[$];
  logic [9:0] exp_ack_q[$];   // {is_read, who, rdata}
  int tx_cnt = 0, rx_cnt = 0, ack_cnt = 0, b_rx_cnt = 0;
  logic [1:0] grant_prev = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RX FIFO models: byte valid for the one cycle around the capture edge
  logic [7:0] rx_byte = 8'h00, b_rx_byte = 8'h00;
  int rx_wait = 0, b_rx_wait = 0;
  always @(negedge clock) begin
    rx_data = 8'hEE;
    if (rx_read) begin
      rx_wait = 1;
    end else if (rx_wait > 0) begin
      rx_wait--;
      if (rx_wait == 0) rx_data = rx_byte;
    end
    b_rx_data = 8'hEE;
    if (b_rx_read) begin
      b_rx_cnt++;
      b_rx_wait = 2;
    end else if (b_rx_wait > 0) begin
      b_rx_wait--;
      if (b_rx_wait == 0) b_rx_data = b_rx_byte;
    end
  end

  // Monitor: pops expected TX bytes, grants and acks as the DUT produces them
  always @(negedge clock) begin
    if (reset) begin
      grant_prev = 2'b00;
    end else begin
      if (tx_write || rx_read) check("strobe_exclusive", tx_write & rx_read, 0);
      if (rx_read) rx_cnt++;
      if (tx_write) begin
        tx_cnt++;
        check("tx_expected", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) check("tx_data", tx_data, exp_tx_q.pop_front());
      end
      if (ack_0 || ack_1) begin
        logic [9:0] e;
        ack_cnt++;
        check("ack_onehot", ack_0 & ack_1, 0);
        check("ack_expected", exp_ack_q.size() != 0, 1);
        if (exp_ack_q.size() != 0) begin
          e = exp_ack_q.pop_front();
          check("ack_who", ack_1, e[8]);
          if (e[9]) check("ack_rdata", ack_1 ? rdata_1 : rdata_0, e[7:0]);
        end
      end
      if (grant != 2'b00 && grant_prev == 2'b00) begin
        check("grant_expected", exp_grant_q.size() != 0, 1);
        if (exp_grant_q.size() != 0) check("grant_order", grant, exp_grant_q.pop_front());
      end
      grant_prev = grant;
    end
  end

  // Driver helpers
  task automatic drive_req(input int who, input logic val, input logic op, input logic [7:0] wd);
    case (who)
      0:       begin req_0 = val; op_0 = op; wdata_0 = wd; end
      1:       begin req_1 = val; op_1 = op; wdata_1 = wd; end
      default: b_req_1 = val;
    endcase
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      0:       return ack_0;
      1:       return ack_1;
      default: return b_ack_1;
    endcase
  endfunction

  // One transaction: raise req, count cycles until ack, drop req on ack
  task automatic run_txn(input int who, input logic op, input logic [7:0] wd, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    @(negedge clock);
    drive_req(who, 1'b1, op, wd);
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ack_of(who)) seen = 1'b1;
    end
    drive_req(who, 1'b0, op, wd);
    check("ack_seen", seen, 1);
  endtask

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, c0, c1, mark, amark;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_grant", grant, 2'b00);
    check("rst_ack", {ack_1, ack_0}, 2'b00);
    check("rst_strobes", {tx_write, rx_read}, 2'b00);
    check("rst_rdata", {rdata_1, rdata_0}, 16'h0000);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_state", fsm_state, ST_IDLE);
    reset = 1'b0;

    // Single write from requester 0
    exp_grant_q.push_back(2'b01);
    exp_tx_q.push_back(8'h41);
    exp_ack_q.push_back({1'b0, 1'b0, 8'h41});
    run_txn(0, OP_WRITE, 8'h41, cyc);
    check("t1_latency", cyc, 3);
    @(negedge clock);
    check("t1_grant_idle", grant, 2'b00);
    check("t1_ack_low", ack_0, 0);

    // Read from requester 1, RD_LAT=1
    rx_byte = 8'h5A;
    mark = rx_cnt;
    exp_grant_q.push_back(2'b10);
    exp_ack_q.push_back({1'b1, 1'b1, 8'h5A});
    run_txn(1, OP_READ, 8'h00, cyc);
    check("t2_latency_lat1", cyc, 4);
    check("t2_one_rx_read", rx_cnt - mark, 1);
    @(negedge clock);
    check("t2_rdata_hold", rdata_1, 8'h5A);

    // Read from requester 1, RD_LAT=2
    b_rx_byte = 8'h5A;
    run_txn(2, OP_READ, 8'h00, cyc);
    check("t2_latency_lat2", cyc, 5);
    check("t2_rdata_lat2", b_rdata_1, 8'h5A);
    check("t2_one_rx_read_lat2", b_rx_cnt, 1);

    // Simultaneous requests: grants alternate
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    exp_tx_q.push_back(8'h10); exp_tx_q.push_back(8'h11);
    exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h21);
    exp_ack_q.push_back({1'b0, 1'b0, 8'h10}); exp_ack_q.push_back({1'b0, 1'b1, 8'h11});
    exp_ack_q.push_back({1'b0, 1'b0, 8'h20}); exp_ack_q.push_back({1'b0, 1'b1, 8'h21});
    fork
      begin run_txn(0, OP_WRITE, 8'h10, c0); run_txn(0, OP_WRITE, 8'h20, c0); end
      begin run_txn(1, OP_WRITE, 8'h11, c1); run_txn(1, OP_WRITE, 8'h21, c1); end
    join
    check("t3_tx_drained", exp_tx_q.size(), 0);

    // TX FIFO full for 5 cycles during ISSUE
    exp_grant_q.push_back(2'b01);
    exp_tx_q.push_back(8'h55);
    exp_ack_q.push_back({1'b0, 1'b0, 8'h55});
    @(negedge clock);
    mark = tx_cnt;
    amark = ack_cnt;
    tx_full = 1'b1;
    drive_req(0, 1'b1, OP_WRITE, 8'h55);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check("t4_no_strobe", tx_write, 0);
    end
    tx_full = 1'b0;
    @(negedge clock);
    check("t4_strobe", tx_write, 1);
    @(negedge clock);
    check("t4_ack", ack_0, 1);
    drive_req(0, 1'b0, OP_WRITE, 8'h55);
    repeat (3) @(negedge clock);
    check("t4_one_strobe", tx_cnt - mark, 1);
    check("t4_one_ack", ack_cnt - amark, 1);

    // Reset during WAIT
    rx_byte = 8'h99;
    exp_grant_q.push_back(2'b10);
    @(negedge clock);
    drive_req(1, 1'b1, OP_READ, 8'h00);
    repeat (2) @(negedge clock);
    check("t5_in_wait", fsm_state, ST_WAIT);
    amark = ack_cnt;
    reset = 1'b1;
    #1;
    check("t5_grant", grant, 2'b00);
    check("t5_ack", {ack_1, ack_0}, 2'b00);
    check("t5_strobes", {tx_write, rx_read}, 2'b00);
    check("t5_rdata", {rdata_1, rdata_0}, 16'h0000);
    check("t5_tx_data", tx_data, 8'h00);
    check("t5_state", fsm_state, ST_IDLE);
    drive_req(1, 1'b0, OP_READ, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("t5_no_ack", ack_cnt - amark, 0);

    // Tie after reset: requester 0 wins first
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    exp_tx_q.push_back(8'hA0); exp_tx_q.push_back(8'hB1);
    exp_ack_q.push_back({1'b0, 1'b0, 8'hA0}); exp_ack_q.push_back({1'b0, 1'b1, 8'hB1});
    fork
      run_txn(0, OP_WRITE, 8'hA0, c0);
      run_txn(1, OP_WRITE, 8'hB1, c1);
    join

`ifdef SERIAL_ARB_LOCK_EN
    // Requester 1 locks the port over 3 reads while requester 0 waits
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    exp_ack_q.push_back({1'b1, 1'b1, 8'h30});
    exp_ack_q.push_back({1'b1, 1'b1, 8'h31});
    exp_ack_q.push_back({1'b1, 1'b1, 8'h32});
    exp_ack_q.push_back({1'b0, 1'b0, 8'h77});
    exp_tx_q.push_back(8'h77);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          lock_1 = (k < 2);
          rx_byte = 8'h30 + 8'(k);
          run_txn(1, OP_READ, 8'h00, c1);
        end
        lock_1 = 1'b0;
      end
      begin
        repeat (2) @(negedge clock);
        run_txn(0, OP_WRITE, 8'h77, c0);
      end
    join
`endif

    repeat (3) @(negedge clock);
    check("end_tx_q_empty", exp_tx_q.size(), 0);
    check("end_ack_q_empty", exp_ack_q.size(), 0);
    check("end_grant_q_empty", exp_grant_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
